// File: rtl/btb_updq_pkg.sv
// ---------------------------------------------------------------------------
// btb_updq_pkg
//   Shared types and constants for the BTB update queue.
//   - UPDQ_PC_BITS  : default PC width (must match the BTB's PC_BITS)
//   - UPDQ_DEPTH    : default queue depth (power of two, >= 2)
//   - UPDQ_PTR_BITS : head/tail pointer width for the default depth
//   - btb_upd_entry_t : one queued branch outcome {pc, target, taken}
// ---------------------------------------------------------------------------
package btb_updq_pkg;

  localparam int UPDQ_PC_BITS  = 32;
  localparam int UPDQ_DEPTH    = 4;
  localparam int UPDQ_PTR_BITS = $clog2(UPDQ_DEPTH);

  typedef struct packed {
    logic [UPDQ_PC_BITS-1:0] pc;
    logic [UPDQ_PC_BITS-1:0] target;
    logic                    taken;
  } btb_upd_entry_t;

endpackage

// File: rtl/btb_updq_storage.sv
// ---------------------------------------------------------------------------
// btb_updq_storage
//   DEPTH x entry_t register array, one write port, one asynchronous read
//   port. Contents are deliberately not reset: validity is tracked by the
//   pointers and occupancy counter in the parent.
//   Ports:
//     clk      in   clock
//     we_i     in   write enable
//     waddr_i  in   write index
//     wdata_i  in   write data
//     raddr_i  in   read index
//     rdata_o  out  read data (combinational from the array)
// ---------------------------------------------------------------------------
module btb_updq_storage
  import btb_updq_pkg::*;
#(
  parameter type entry_t  = btb_upd_entry_t,
  parameter int  DEPTH    = UPDQ_DEPTH,
  parameter int  PTR_BITS = UPDQ_PTR_BITS
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [PTR_BITS-1:0] waddr_i,
  input  entry_t              wdata_i,
  input  logic [PTR_BITS-1:0] raddr_i,
  output entry_t              rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/btb_update_queue.sv
// ---------------------------------------------------------------------------
// btb_update_queue
//   FIFO between branch resolution and the BTB's single write port. Each
//   resolved branch is queued and drained one per cycle: taken outcomes
//   become BTB writes {orig_pc, target_pc}, not-taken outcomes become line
//   invalidations. The head entry is presented combinationally from
//   registers, so an accepted push reaches the BTB no earlier than the next
//   cycle.
//
//   Handshake: a push happens on a rising edge where in_valid && in_ready.
//   in_ready depends only on registered occupancy (no path from in_valid);
//   a full queue refuses pushes even in a cycle where it pops.
//
//   Optional build macro BTB_UPDQ_COALESCE_EN: a push whose PC matches the
//   youngest queued entry overwrites that entry's target/taken in place
//   instead of allocating, unless that entry is the sole entry and is being
//   drained this same cycle.
//
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     in_valid/ready   push handshake
//     in_pc/target     resolved branch PC and target
//     in_taken         1 = BTB write, 0 = BTB invalidate
//     hold             suspend draining this cycle
//     wr_en/orig_pc/target_pc  BTB write port
//     invalidate/pc_invalid    BTB invalidation port
//     occupancy        number of valid entries
// ---------------------------------------------------------------------------
module btb_update_queue
  import btb_updq_pkg::*;
#(
  parameter int PC_BITS = UPDQ_PC_BITS,
  parameter int DEPTH   = UPDQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_BITS-1:0]       in_pc,
  input  logic [PC_BITS-1:0]       in_target,
  input  logic                     in_taken,
  input  logic                     hold,
  output logic                     wr_en,
  output logic [PC_BITS-1:0]       orig_pc,
  output logic [PC_BITS-1:0]       target_pc,
  output logic                     invalidate,
  output logic [PC_BITS-1:0]       pc_invalid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] target;
    logic               taken;
  } entry_t;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             push;
  logic             pop;
  logic             coalesce;
  logic             alloc;
  logic             st_we;
  logic [PTR_W-1:0] st_waddr;
  entry_t           st_wdata;
  entry_t           head_entry;

`ifdef BTB_UPDQ_COALESCE_EN
  // PC of the youngest allocated entry, kept in a flop so the coalesce
  // compare does not need a second read port on the storage array.
  logic [PC_BITS-1:0] young_pc_q, young_pc_d;
`endif

  assign in_ready = (occ_q != OCC_W'(DEPTH));

  always_comb begin
    push     = in_valid && in_ready;
    pop      = (occ_q != OCC_W'(0)) && !hold;
    coalesce = 1'b0;
`ifdef BTB_UPDQ_COALESCE_EN
    // Never merge into an entry that is leaving through the BTB port now.
    coalesce = push && (occ_q != OCC_W'(0)) && (young_pc_q == in_pc) &&
               !((occ_q == OCC_W'(1)) && pop);
`endif
    alloc    = push && !coalesce;

    st_we    = push;
    st_waddr = coalesce ? (tail_q - PTR_W'(1)) : tail_q;
    st_wdata = '{pc: in_pc, target: in_target, taken: in_taken};

    tail_d   = alloc ? (tail_q + PTR_W'(1)) : tail_q;
    head_d   = pop   ? (head_q + PTR_W'(1)) : head_q;

    occ_d    = occ_q;
    case ({alloc, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

`ifdef BTB_UPDQ_COALESCE_EN
    young_pc_d = alloc ? in_pc : young_pc_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

`ifdef BTB_UPDQ_COALESCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      young_pc_q <= '0;
    end else begin
      young_pc_q <= young_pc_d;
    end
  end
`endif

  btb_updq_storage #(
    .entry_t  (entry_t),
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (st_we),
    .waddr_i (st_waddr),
    .wdata_i (st_wdata),
    .raddr_i (head_q),
    .rdata_o (head_entry)
  );

  // Head entry drives exactly one of the two BTB strobes when popping.
  assign wr_en      = pop &&  head_entry.taken;
  assign invalidate = pop && !head_entry.taken;
  assign orig_pc    = head_entry.pc;
  assign target_pc  = head_entry.target;
  assign pc_invalid = head_entry.pc;
  assign occupancy  = occ_q;

endmodule
